// File: rtl/seq_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_dec_pkg
// Description : Shared constants for the control-unit timing / opcode decode
//               stage: default widths, instruction field positions, memory
//               reference opcode indices and timing-step indices.
// Revision    : 1.0  initial release
// ============================================================================
package seq_dec_pkg;

  // Default sequence counter width and resulting timing-signal count
  localparam int SC_W_DEF  = 4;
  localparam int NUM_T_DEF = 16;
  localparam int IR_W_DEF  = 16;

  // Instruction register field positions for the 16-bit basic computer
  localparam int OP_MSB = 14;
  localparam int OP_LSB = 12;
  localparam int I_POS  = 15;
  localparam int OP_W   = OP_MSB - OP_LSB + 1;

  // One-hot D[] indices for each opcode
  localparam int D_AND = 0;
  localparam int D_ADD = 1;
  localparam int D_LDA = 2;
  localparam int D_STA = 3;
  localparam int D_BUN = 4;
  localparam int D_BSA = 5;
  localparam int D_ISZ = 6;
  localparam int D_RIO = 7;

  // Timing steps with fixed meaning in the instruction cycle
  localparam int T_FETCH0 = 0;
  localparam int T_FETCH1 = 1;
  localparam int T_DECODE = 2;
  localparam int T_EXEC   = 3;

  // Number of one-hot outputs produced from an in_w-bit binary value
  function automatic int onehot_width(input int in_w);
    return 1 << in_w;
  endfunction

endpackage : seq_dec_pkg
`default_nettype wire

// File: rtl/seq_timing_decoder_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module      : onehot_dec
// Description : Binary to one-hot decoder, onehot = 1 << bin. Purely
//               combinational; output is always exactly one-hot.
// Revision    : 1.0  initial release
// ============================================================================
module onehot_dec
  import seq_dec_pkg::*;
#(
  parameter int IN_W = 3
) (
  input  logic [IN_W-1:0]               bin,
  output logic [onehot_width(IN_W)-1:0] onehot
);

  localparam int c_OUT_W = onehot_width(IN_W);

  // Compare every output position with the input code
  always_comb begin
    onehot = '0;
    for (int k = 0; k < c_OUT_W; k++) begin
      onehot[k] = (bin == IN_W'(k));
    end
  end

endmodule : onehot_dec
`default_nettype wire

// File: rtl/seq_timing_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seq_timing_decoder
// Description : Control-unit timing and opcode decode stage. Holds the
//               sequence counter SC, drives one-hot timing signals T from it
//               combinationally, and latches a one-hot opcode decode D plus
//               the indirect bit I from the instruction register.
//               Optional macro SEQ_DEC_WRAP_ERR_EN adds a sticky sc_err flag
//               that records an un-cleared wrap of SC from NUM_T-1 to 0.
// Revision    : 1.0  initial release
// ============================================================================
module seq_timing_decoder
  import seq_dec_pkg::*;
#(
  parameter int SC_W  = SC_W_DEF,
  parameter int NUM_T = NUM_T_DEF,
  parameter int IR_W  = IR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sc_clr,
  input  logic             sc_inr,
  input  logic             ir_load,
  input  logic [IR_W-1:0]  ir_in,
  output logic [SC_W-1:0]  sc,
  output logic [NUM_T-1:0] t,
  output logic [7:0]       d,
  output logic             i_bit
`ifdef SEQ_DEC_WRAP_ERR_EN
  ,
  output logic             sc_err
`endif
);

  localparam int c_OPC_W = 3;

  logic [SC_W-1:0]    r_sc;
  logic [7:0]         r_d;
  logic               r_i;
  logic [NUM_T-1:0]   w_t;
  logic [c_OPC_W-1:0] w_opcode;
  logic [7:0]         w_d_next;
  logic               w_unused_ir;

  // Opcode field sits just below the I bit at the top of the IR
  assign w_opcode    = ir_in[IR_W-2:IR_W-4];
  // Address bits are not used by this stage
  assign w_unused_ir = ^ir_in[IR_W-5:0];

  // Sequence counter: reset, then clear, then increment (natural wrap)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sc <= '0;
    end else if (sc_clr) begin
      r_sc <= '0;
    end else if (sc_inr) begin
      r_sc <= r_sc + 1'b1;
    end
  end

  // Timing signals are a zero-latency decode of the counter register
  onehot_dec #(
    .IN_W   (SC_W)
  ) u_t_dec (
    .bin    (r_sc),
    .onehot (w_t)
  );

  // Opcode decode ahead of the D register
  onehot_dec #(
    .IN_W   (c_OPC_W)
  ) u_d_dec (
    .bin    (w_opcode),
    .onehot (w_d_next)
  );

  // D and I capture on ir_load, independent of the counter controls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d <= '0;
      r_i <= 1'b0;
    end else if (ir_load) begin
      r_d <= w_d_next;
      r_i <= ir_in[IR_W-1];
    end
  end

  assign sc    = r_sc;
  assign t     = w_t;
  assign d     = r_d;
  assign i_bit = r_i;

`ifdef SEQ_DEC_WRAP_ERR_EN
  logic r_sc_err;
  logic w_wrap;

  // A wrap is an increment out of the last step that no clear pre-empted
  assign w_wrap = (r_sc == SC_W'(NUM_T - 1)) && sc_inr && !sc_clr;

  // Sticky wrap flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sc_err <= 1'b0;
    end else if (w_wrap) begin
      r_sc_err <= 1'b1;
    end
  end

  assign sc_err = r_sc_err;
`endif

endmodule : seq_timing_decoder
`default_nettype wire

// File: tb/tb_seq_timing_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_timing_decoder
// Description : Self-checking bench for seq_timing_decoder. A behavioural
//               model tracks SC as an integer, D as 2**opcode and the I/err
//               flags; the outputs are compared with it every cycle, and
//               directed steps also pin hand-computed literal values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seq_timing_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sc_clr = 1'b0;
  logic        sc_inr = 1'b0;
  logic        ir_load = 1'b0;
  logic [15:0] ir_in = 16'h0000;
  logic [3:0]  sc;
  logic [15:0] t;
  logic [7:0]  d;
  logic        i_bit;
`ifdef SEQ_DEC_WRAP_ERR_EN
  logic        sc_err;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  int m_sc    = 0;
  int m_d     = 0;
  int m_i     = 0;
  int m_err   = 0;
  bit m_valid = 1'b0;

  seq_timing_decoder dut (
    .clk     (clk),
    .rst     (rst),
    .sc_clr  (sc_clr),
    .sc_inr  (sc_inr),
    .ir_load (ir_load),
    .ir_in   (ir_in),
    .sc      (sc),
    .t       (t),
    .d       (d),
    .i_bit   (i_bit)
`ifdef SEQ_DEC_WRAP_ERR_EN
    ,
    .sc_err  (sc_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: counter as integer modulo 16, D as a power of two of the opcode
  always @(posedge clk) begin
    if (rst) begin
      m_sc    <= 0;
      m_d     <= 0;
      m_i     <= 0;
      m_err   <= 0;
      m_valid <= 1'b1;
    end else begin
      if (sc_clr) begin
        m_sc <= 0;
      end else if (sc_inr) begin
        m_sc <= (m_sc + 1) % 16;
        if (m_sc == 15) m_err <= 1;
      end
      if (ir_load) begin
        m_d <= 2 ** ((ir_in / 4096) % 8);
        m_i <= ir_in / 32768;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_sc", {28'd0, sc}, m_sc);
      chk("model_t", {16'd0, t}, 1 << m_sc);
      chk("model_d", {24'd0, d}, m_d);
      chk("model_i", {31'd0, i_bit}, m_i);
`ifdef SEQ_DEC_WRAP_ERR_EN
      chk("model_err", {31'd0, sc_err}, m_err);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_err(input string name, input int exp);
`ifdef SEQ_DEC_WRAP_ERR_EN
    chk(name, {31'd0, sc_err}, exp);
`endif
  endtask

  initial begin
    // Reset held two cycles while other controls are active
    rst = 1'b1; sc_inr = 1'b1; ir_load = 1'b1; ir_in = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("rst_sc", {28'd0, sc}, 32'h0);
      chk("rst_t", {16'd0, t}, 32'h0001);
      chk("rst_d", {24'd0, d}, 32'h00);
      chk("rst_i", {31'd0, i_bit}, 32'h0);
      chk_err("rst_err", 0);
    end

    // Count 17 steps: 1..15, wrap to 0, then 1
    rst = 1'b0; ir_load = 1'b0; sc_inr = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      cyc();
      chk("cnt_sc", {28'd0, sc}, k % 16);
      chk("cnt_t", {16'd0, t}, 1 << (k % 16));
      chk_err("cnt_err", (k >= 16) ? 1 : 0);
    end

    // Fresh reset, count to 5, then clear and increment together
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    chk("pre_clr_sc", {28'd0, sc}, 32'd5);
    sc_clr = 1'b1; cyc(); sc_clr = 1'b0;
    chk("clr_sc", {28'd0, sc}, 32'd0);
    chk("clr_t", {16'd0, t}, 32'h0001);
    chk_err("clr_err", 0);

    // Opcode decode, then hold while ir_in toggles
    sc_inr = 1'b0; ir_load = 1'b1; ir_in = 16'h7800;
    cyc();
    chk("op7_d", {24'd0, d}, 32'h80);
    chk("op7_i", {31'd0, i_bit}, 32'h0);
    ir_in = 16'hA123;
    cyc();
    chk("op2_d", {24'd0, d}, 32'h04);
    chk("op2_i", {31'd0, i_bit}, 32'h1);
    ir_load = 1'b0; ir_in = 16'h7800; cyc();
    ir_in = 16'hFFFF; cyc();
    chk("hold_d", {24'd0, d}, 32'h04);
    chk("hold_i", {31'd0, i_bit}, 32'h1);

    // Step to sc=2, then load and increment in the same edge
    sc_inr = 1'b1; cyc(); cyc();
    chk("pre_conc_sc", {28'd0, sc}, 32'd2);
    ir_load = 1'b1; ir_in = 16'h3000;
    cyc();
    chk("conc_sc", {28'd0, sc}, 32'd3);
    chk("conc_t", {16'd0, t}, 32'h0008);
    chk("conc_d", {24'd0, d}, 32'h08);
    chk("conc_i", {31'd0, i_bit}, 32'h0);

    // Load and clear in the same edge both take effect
    ir_in = 16'hE000; sc_clr = 1'b1;
    cyc();
    sc_clr = 1'b0;
    chk("clrld_sc", {28'd0, sc}, 32'd0);
    chk("clrld_d", {24'd0, d}, 32'h40);
    chk("clrld_i", {31'd0, i_bit}, 32'h1);

    // Build sc=9, d=8'h20, then reset mid-instruction
    ir_in = 16'h5000;
    for (int k = 0; k < 9; k++) begin
      cyc();
      ir_load = 1'b0;
    end
    chk("pre_mid_sc", {28'd0, sc}, 32'd9);
    chk("pre_mid_d", {24'd0, d}, 32'h20);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_sc", {28'd0, sc}, 32'd0);
    chk("mid_t", {16'd0, t}, 32'h0001);
    chk("mid_d", {24'd0, d}, 32'h00);
    chk("mid_i", {31'd0, i_bit}, 32'h0);
    chk_err("mid_err", 0);
    cyc();
    chk("resume_sc", {28'd0, sc}, 32'd1);
    chk("resume_t", {16'd0, t}, 32'h0002);

    sc_inr = 1'b0;
    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_seq_timing_decoder
`default_nettype wire
